// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrated multiplexer family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// PRIO_RR / PRIO_FIXED select the arbitration policy; idx_w() gives the
// width of a binary channel index, never narrower than one bit.
package mux_pkg;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr, or fixed lowest-index priority.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller gates the grant with its own load condition.
//
// Ports:
//   req     - per-channel requests
//   ptr     - round-robin start index (ignored when mode = 1)
//   mode    - 0 = round-robin, 1 = fixed priority
//   gnt     - one-hot grant, all zero when no request
//   gnt_idx - binary index of the granted channel
//   any     - at least one request present
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // Scan N candidates in priority order; the first requester wins.
        for (int k = 0; k < N; k++) begin
            if (mode) begin
                idx = k;
            end else begin
                // Explicit wrap keeps the scan correct for non-power-of-2 N.
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = SW'(idx);
            end
        end
        any = found;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated mux with a one-deep registered output stage.
// Latency: word accepted in cycle t appears on out_* in cycle t+1; one word per cycle.
// Backpressure: while out_valid && !out_ready the output holds and all in_ready stay low.
//
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   in_data    - N packed channels, channel i at [i*K +: K]
//   in_valid   - per-channel request
//   in_ready   - per-channel accept, at most one bit high, low during reset
//   out_data   - registered winning word
//   out_sel    - index of the channel that produced out_data
//   out_valid  - out_data/out_sel hold a word
//   out_ready  - consumer takes the output word
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int K         = 32,
    parameter int N         = 4,
    parameter int PRIO_MODE = PRIO_RR,
    localparam int SW       = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*K-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [K-1:0]     out_data,
    output logic [SW-1:0]    out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic FIXED = (PRIO_MODE == PRIO_FIXED);

    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_nxt;
    logic [N-1:0]  gnt;
    logic [SW-1:0] gnt_idx;
    logic          any;
    logic          load;
    logic          xfer;
    logic [K-1:0]  win_data;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .mode    (FIXED),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // The output register can take a word when it is empty or being drained.
    assign load = !out_valid || out_ready;

    // Reset forces every accept low so no producer believes a word was taken.
    assign xfer     = load && any && !rst;
    assign in_ready = xfer ? gnt : '0;

    assign win_data = in_data[gnt_idx*K +: K];

    // Pointer moves one past the winner, wrapping at N-1 rather than 2**SW-1.
    assign ptr_nxt = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any) begin
                out_data  <= win_data;
                out_sel   <= gnt_idx;
                out_valid <= 1'b1;
                if (!FIXED) begin
                    ptr <= ptr_nxt;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (N=4 round-robin, N=4 fixed, N=3 K=8 round-robin).
// Latency: expected words are queued when the model predicts an accept, checked one edge later.
// Backpressure: the model tracks out_valid/out_ready and expects all in_ready low while holding.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [127:0] a_data, f_data;
    logic [3:0]   a_valid, f_valid, a_ready, f_ready;
    logic [31:0]  a_odata, f_odata;
    logic [1:0]   a_osel, f_osel;
    logic         a_ovalid, f_ovalid, a_oready, f_oready;

    logic [23:0]  c_data;
    logic [2:0]   c_valid, c_ready;
    logic [7:0]   c_odata;
    logic [1:0]   c_osel;
    logic         c_ovalid, c_oready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          d;
        int          sel;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   m_ptr[3];
    bit   m_ov[3];
    int   nch[3] = '{4, 4, 3};
    bit   fx[3]  = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    rr_arb_mux #(.K(32), .N(4), .PRIO_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ovalid), .out_ready(a_oready)
    );

    rr_arb_mux #(.K(32), .N(4), .PRIO_MODE(1)) dut_f (
        .clk(clk), .rst(rst), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
        .out_data(f_odata), .out_sel(f_osel), .out_valid(f_ovalid), .out_ready(f_oready)
    );

    rr_arb_mux #(.K(8), .N(3), .PRIO_MODE(0)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .out_data(c_odata), .out_sel(c_osel), .out_valid(c_ovalid), .out_ready(c_oready)
    );

    // Reference winner: fixed = lowest set bit, round-robin = first set bit from p upward.
    function automatic int pick(input logic [3:0] v, input int p, input int n, input bit fixed);
        for (int k = 0; k < n; k++) begin
            int i;
            i = fixed ? k : (p + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        sb.delete();
        for (int d = 0; d < 3; d++) begin
            m_ptr[d] = 0;
            m_ov[d]  = 1'b0;
        end
    endfunction

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick();
        logic [3:0]  v[3];
        logic [3:0]  r[3];
        logic        ordy[3];
        logic [31:0] dat[3][4];
        logic        ov[3];
        int          os[3];
        logic [31:0] od[3];
        #1;
        v[0] = a_valid; v[1] = f_valid; v[2] = {1'b0, c_valid};
        r[0] = a_ready; r[1] = f_ready; r[2] = {1'b0, c_ready};
        ordy[0] = a_oready; ordy[1] = f_oready; ordy[2] = c_oready;
        for (int i = 0; i < 4; i++) begin
            dat[0][i] = a_data[i*32 +: 32];
            dat[1][i] = f_data[i*32 +: 32];
            dat[2][i] = (i < 3) ? {24'h0, c_data[i*8 +: 8]} : 32'h0;
        end
        for (int d = 0; d < 3; d++) begin
            bit         load;
            int         w;
            logic [3:0] er;
            load = !m_ov[d] || ordy[d];
            w    = pick(v[d], m_ptr[d], nch[d], fx[d]);
            er   = (load && w >= 0) ? 4'(1 << w) : 4'b0;
            checks++;
            if (r[d] !== er) begin
                errors++;
                $display("FAIL in_ready dut%0d: got %b expected %b", d, r[d], er);
            end
            if (load) begin
                if (m_ov[d]) begin
                    for (int i = 0; i < sb.size(); i++) begin
                        if (sb[i].d == d) begin
                            sb.delete(i);
                            break;
                        end
                    end
                end
                if (w >= 0) begin
                    exp_t e;
                    e.d = d; e.sel = w; e.dat = dat[d][w];
                    sb.push_back(e);
                    m_ov[d] = 1'b1;
                    if (!fx[d]) m_ptr[d] = (w + 1) % nch[d];
                end else begin
                    m_ov[d] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        ov[0] = a_ovalid; ov[1] = f_ovalid; ov[2] = c_ovalid;
        os[0] = int'(a_osel); os[1] = int'(f_osel); os[2] = int'(c_osel);
        od[0] = a_odata; od[1] = f_odata; od[2] = {24'h0, c_odata};
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== m_ov[d]) begin
                errors++;
                $display("FAIL out_valid dut%0d: got %b expected %b", d, ov[d], m_ov[d]);
            end
            if (m_ov[d]) begin
                int idx;
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (idx < 0 && sb[i].d == d) idx = i;
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL scoreboard dut%0d: no expected word queued", d);
                end else if (os[d] !== sb[idx].sel || od[d] !== sb[idx].dat) begin
                    errors++;
                    $display("FAIL out_word dut%0d: got sel=%0d data=%h expected sel=%0d data=%h",
                             d, os[d], od[d], sb[idx].sel, sb[idx].dat);
                end
            end
        end
    endtask

    task automatic test_reset();
        a_valid = 4'b1111; f_valid = 4'b1111; c_valid = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_ready !== 4'b0 || f_ready !== 4'b0 || c_ready !== 3'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b %b %b expected all zero", a_ready, f_ready, c_ready);
        end
        checks++;
        if (a_ovalid !== 1'b0 || a_osel !== 2'd0 || a_odata !== 32'h0 ||
            c_ovalid !== 1'b0 || c_osel !== 2'd0 || c_odata !== 8'h0) begin
            errors++;
            $display("FAIL reset_out: got a=%b/%0d/%h c=%b/%0d/%h expected zeros",
                     a_ovalid, a_osel, a_odata, c_ovalid, c_osel, c_odata);
        end
        a_valid = 4'b0; f_valid = 4'b0; c_valid = 3'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_rr_rotation();
        int exp_sel[5] = '{0, 1, 2, 3, 0};
        a_data  = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        a_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (a_osel !== 2'(exp_sel[i])) begin
                errors++;
                $display("FAIL rr_seq step%0d: got %0d expected %0d", i, a_osel, exp_sel[i]);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        checks++;
        if (a_osel !== 2'd2 || a_odata !== 32'hCCCC_CCCC) begin
            errors++;
            $display("FAIL bp_setup: got sel=%0d data=%h expected 2/cccccccc", a_osel, a_odata);
        end
        a_oready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_osel !== 2'd2 || a_odata !== 32'hCCCC_CCCC || a_ready !== 4'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: got sel=%0d data=%h rdy=%b expected 2/cccccccc/0000",
                         i, a_osel, a_odata, a_ready);
            end
        end
        a_oready = 1'b1;
        tick();
        checks++;
        if (a_osel !== 2'd3 || a_odata !== 32'hDDDD_DDDD) begin
            errors++;
            $display("FAIL bp_release: got sel=%0d data=%h expected 3/dddddddd", a_osel, a_odata);
        end
        a_valid = 4'b0;
    endtask

    task automatic test_fixed_prio();
        f_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        f_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (f_osel !== 2'd1) begin
                errors++;
                $display("FAIL fixed_starve cyc%0d: got sel=%0d expected 1", i, f_osel);
            end
        end
        f_valid = 4'b1000;
        tick();
        checks++;
        if (f_osel !== 2'd3 || f_odata !== 32'h4444_4444) begin
            errors++;
            $display("FAIL fixed_release: got sel=%0d data=%h expected 3/44444444", f_osel, f_odata);
        end
        f_valid = 4'b0;
        tick();
    endtask

    task automatic test_wrap_n3();
        logic [2:0] vseq[5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b111};
        int         sseq[5] = '{1, 0, 1, 2, 0};
        c_data = {8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 5; i++) begin
            c_valid = vseq[i];
            tick();
            checks++;
            if (c_osel !== 2'(sseq[i])) begin
                errors++;
                $display("FAIL wrap_n3 step%0d: got sel=%0d expected %0d", i, c_osel, sseq[i]);
            end
        end
        c_valid = 3'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        a_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_ovalid !== 1'b1 || a_osel !== 2'd2) begin
                errors++;
                $display("FAIL b2b cyc%0d: got valid=%b sel=%0d expected 1/2", i, a_ovalid, a_osel);
            end
        end
    endtask

    task automatic test_idle_drain();
        a_valid = 4'b0001;
        tick();
        a_valid = 4'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_ovalid !== 1'b0) begin
                errors++;
                $display("FAIL drain cyc%0d: got out_valid=%b expected 0", i, a_ovalid);
            end
        end
        // Pointer parked at 1 after the grant to channel 0; idling must not move it.
        a_valid = 4'b1111;
        tick();
        checks++;
        if (a_osel !== 2'd1) begin
            errors++;
            $display("FAIL idle_ptr: got sel=%0d expected 1", a_osel);
        end
        a_valid = 4'b0;
        tick();
    endtask

    task automatic test_reset_midcycle();
        a_valid = 4'b1111; f_valid = 4'b1111; c_valid = 3'b111;
        a_oready = 1'b0;
        tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (a_ovalid !== 1'b0 || a_osel !== 2'd0 || a_odata !== 32'h0 ||
            f_ovalid !== 1'b0 || c_ovalid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got a=%b/%0d/%h f=%b c=%b expected zeros",
                     a_ovalid, a_osel, a_odata, f_ovalid, c_ovalid);
        end
        checks++;
        if (a_ready !== 4'b0 || f_ready !== 4'b0 || c_ready !== 3'b0) begin
            errors++;
            $display("FAIL reset_ready_mid: got %b %b %b expected zero", a_ready, f_ready, c_ready);
        end
        a_oready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a_ovalid !== 1'b0 || a_ready !== 4'b0 || f_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_hold: got valid=%b rdy=%b/%b expected 0/0000/0000",
                     a_ovalid, a_ready, f_ready);
        end
        a_valid = 4'b0; f_valid = 4'b0; c_valid = 3'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        // Pointer must be back at 0: from 0 the winner of 1001 is 0, from 3 it would be 3.
        a_valid = 4'b1001;
        tick();
        checks++;
        if (a_osel !== 2'd0 || a_odata !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL post_reset_ptr: got sel=%0d data=%h expected 0/aaaaaaaa", a_osel, a_odata);
        end
        a_valid = 4'b0;
        tick();
    endtask

    initial begin
        a_data = '0; f_data = '0; c_data = '0;
        a_valid = '0; f_valid = '0; c_valid = '0;
        a_oready = 1'b1; f_oready = 1'b1; c_oready = 1'b1;
        model_reset();
        test_reset();
        test_rr_rotation();
        test_backpressure();
        test_fixed_prio();
        test_wrap_n3();
        test_back_to_back();
        test_idle_drain();
        test_reset_midcycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Registered, parametrised N-channel multiplexer with valid/ready handshakes and built-in arbitration. It generalises the datapath 4:1 select mux: the select is produced internally by a round-robin or fixed-priority arbiter instead of being driven as an external SEL. The block sits where several producers (ALU result, memory read-back, immediate path, forwarding paths) compete for one destination bus. The output is a one-deep registered stage.

## Interface
- `K`, default 32: data width per channel.
- `N`, default 4: channel count, N ≥ 2.
- `PRIO_MODE`, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `SW`: derived as $clog2(N), not overridable; width of the select/grant index.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input N*K: channel i occupies bits [i*K +: K].
- `in_valid` input N: per-channel request.
- `in_ready` output N: per-channel accept, at most one bit high.
- `out_data` output K: registered selected data.
- `out_sel` output SW: index of the channel that produced `out_data`.
- `out_valid` output 1: `out_data` and `out_sel` are valid.
- `out_ready` input 1: consumer accepts the output.

## Operation
- `load = !out_valid || out_ready`: the output register can take a new word this cycle.
- Winner selection when `load` is high and any `in_valid` bit is set:
  - Round-robin: the first set bit scanning upward from `ptr`, wrapping from N-1 to 0.
  - Fixed priority: the lowest set index; `ptr` is unused.
- Winner handshake: `in_ready[w] = load`, all other `in_ready` bits = 0. The handshake and the transfer complete in the same cycle.
- On a transfer:
  - `out_data <= in_data[w]`, `out_sel <= w`, `out_valid <= 1`.
  - Round-robin only: `ptr <= (w+1) mod N`, with explicit wrap for non-power-of-2 N.
- `load` high, no requests: `out_valid <= 0` if `out_ready`; `ptr` unchanged.
- Holding: `out_valid && !out_ready` → `out_data`/`out_sel` held stable, all `in_ready` = 0, `ptr` held.
- Producers keep `in_valid` and `in_data` stable until accepted; the block never drops an accepted word.
- Reset values (asynchronous):
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `ptr` = 0.
  - `in_ready` = 0 while `rst` is high, forced combinationally.
- Reset mid-transfer: a held output word is discarded; no transfer occurs in any cycle where `rst` is high.
- Single requester: served back-to-back every cycle while `out_ready` = 1, in both modes.

## Timing
- Latency: accept in cycle t → `out_valid`/`out_data` visible in cycle t+1.
- Throughput: one word per cycle with `out_ready` held high.
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready`, `ptr` and `rst`. `out_*` are pure register outputs.
- Round-robin fairness: a continuously requesting channel is granted within N transfers.
- `ptr` update and output load happen on the same edge.

## Structure
- Shared package `mux_pkg`:
  - `PRIO_RR` = 0, `PRIO_FIXED` = 1.
  - Function `idx_w(n)` computing the $clog2 width with a floor of 1.
- Sub-module `rr_arbiter`:
  - Inputs: `req[N]`, `ptr`, `mode`.
  - Outputs: one-hot `gnt[N]`, binary `gnt_idx`, `any`.
  - Purely combinational.
- `rr_arb_mux` owns `ptr`, the output register and the handshake logic.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `in_valid` = 4'b1111 → `out_valid`, `out_sel`, `out_data` go 0 immediately; `in_ready` = 0 throughout reset.
- Round-robin rotation (N=4, K=32): `in_data` = {D,C,B,A} = 0xDDDD_DDDD…0xAAAA_AAAA, `in_valid` = 4'b1111, `out_ready` = 1 → `out_sel` sequence 0,1,2,3,0 on consecutive cycles, data matches.
- Backpressure: `out_valid` = 1 with `out_sel` = 2 and `out_data` = 0xCCCC_CCCC, `out_ready` = 0 for 3 cycles → output held stable, `in_ready` = 0; `out_ready` = 1 → next word is channel 3.
- Fixed priority (PRIO_MODE=1): `in_valid` = 4'b1010 held → channel 1 granted every cycle and channel 3 starves; drop `in_valid[1]` → channel 3 granted next cycle.
- Wrap and sparse requests (N=3, K=8): `ptr` = 2, `in_valid` = 3'b001 → grant 0, `ptr` becomes 1; `in_valid` = 3'b100 → grant 2, `ptr` wraps to 0.
- Idle drain: single word accepted, then `in_valid` = 0 with `out_ready` = 1 → `out_valid` high for exactly one cycle, then 0; `ptr` unchanged while idle.
